// File: rtl/clk_rst_seq_pkg.sv
// Shared types for the clock/reset bring-up sequencer.
// Release order is the declaration order of domain_e.
package clk_rst_seq_pkg;

  localparam int REF_W = 4;
  localparam int FB_W  = 12;
  localparam int N_DOM = 5;

  typedef enum logic [2:0] {
    IDLE,
    PLL_WAIT,
    RELEASE,
    RUN,
    FAULT
  } seq_state_e;

  typedef enum logic [1:0] {
    NONE      = 2'd0,
    TIMEOUT   = 2'd1,
    LOCK_LOSS = 2'd2
  } err_code_e;

  typedef enum logic [2:0] {
    SL,
    PL,
    CL,
    P_CORE,
    E_CORE
  } domain_e;

  function automatic logic [REF_W-1:0] fix_ref(
    input logic [REF_W-1:0] v
  );
    return (v == '0) ? REF_W'(1) : v;
  endfunction

  function automatic logic [FB_W-1:0] fix_fb(
    input logic [FB_W-1:0] v
  );
    return (v == '0) ? FB_W'(1) : v;
  endfunction

endpackage

// File: rtl/clk_rst_seq_if.sv
// Divider-write handshake between a config master
// and the bring-up sequencer.
interface clk_rst_seq_if;
  import clk_rst_seq_pkg::*;

  logic             cfg_valid_i;
  logic             cfg_ready_o;
  logic [1:0]       cfg_sel_i;
  logic [REF_W-1:0] cfg_ref_div_i;
  logic [FB_W-1:0]  cfg_fb_div_i;

  modport master (
    output cfg_valid_i,
    output cfg_sel_i,
    output cfg_ref_div_i,
    output cfg_fb_div_i,
    input  cfg_ready_o
  );

  modport slave (
    input  cfg_valid_i,
    input  cfg_sel_i,
    input  cfg_ref_div_i,
    input  cfg_fb_div_i,
    output cfg_ready_o
  );

endinterface

// File: rtl/cdc_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level,
// with a synchronous clear.
module cdc_sync_2ff (
  input  logic clk_i,
  input  logic clr_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/clk_rst_seq.sv
// PLL bring-up sequencer: divider config, lock wait,
// ordered clock/reset release and lock supervision.
module clk_rst_seq
  import clk_rst_seq_pkg::*;
#(
  parameter int               LOCK_TIMEOUT_CYCLES = 4096,
  parameter int               LOCK_STABLE_CYCLES  = 8,
  parameter int               RST_GAP_CYCLES      = 16,
  parameter logic [REF_W-1:0] DEF_REF_DIV         = 4'd1,
  parameter logic [FB_W-1:0]  DEF_FB_DIV          = 12'd40
) (
  input  logic             ref_clk_i,
  input  logic             srst_i,
  input  logic             start_i,
  clk_rst_seq_if.slave     cfg,
  output logic [REF_W-1:0] pll_ref_div_e_core_o,
  output logic [REF_W-1:0] pll_ref_div_p_core_o,
  output logic [REF_W-1:0] pll_ref_div_sl_o,
  output logic [FB_W-1:0]  pll_fb_div_e_core_o,
  output logic [FB_W-1:0]  pll_fb_div_p_core_o,
  output logic [FB_W-1:0]  pll_fb_div_sl_o,
  input  logic             pll_locked_e_core_i,
  input  logic             pll_locked_p_core_i,
  input  logic             pll_locked_sl_i,
  output logic             clk_en_e_core_o,
  output logic             clk_en_p_core_o,
  output logic             clk_en_cl_o,
  output logic             clk_en_sl_o,
  output logic             clk_en_pl_o,
  output logic             arst_e_core_no,
  output logic             arst_p_core_no,
  output logic             arst_cl_no,
  output logic             arst_sl_no,
  output logic             arst_pl_no,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [1:0]       err_code_o,
  output logic [2:0]       err_pll_o
);

  localparam int TW = $clog2(LOCK_TIMEOUT_CYCLES + 1);
  localparam int SW = $clog2(LOCK_STABLE_CYCLES + 1);
  localparam int GW = $clog2(RST_GAP_CYCLES + 1);

  localparam logic [TW-1:0] TMO_MAX  = TW'(LOCK_TIMEOUT_CYCLES);
  localparam logic [SW-1:0] STB_MAX  = SW'(LOCK_STABLE_CYCLES);
  localparam logic [GW-1:0] GAP_LAST = GW'(RST_GAP_CYCLES - 1);

  seq_state_e           state_q;
  domain_e              step_q;
  domain_e              step_nx;
  logic                 phase_q;
  logic [TW-1:0]        tmo_q, tmo_d;
  logic [SW-1:0]        stb_q, stb_d;
  logic [GW-1:0]        gap_q, gap_d;
  logic [N_DOM-1:0]     clk_en_q;
  logic [N_DOM-1:0]     arst_n_q;
  logic                 busy_q, done_q, ready_q;
  logic                 err_q;
  err_code_e            code_q;
  logic [2:0]           epll_q;
  logic [2:0][REF_W-1:0] ref_q;
  logic [2:0][FB_W-1:0]  fb_q;

  logic [2:0] lock_s;
  logic       all_lock;
  logic       sync_clr;
  logic       cfg_fire;
  logic       gap_end;
  logic       lost;
  logic       tmo_hit;

  // Locks re-qualify from scratch on every sequence start.
  assign sync_clr = srst_i
                  | (state_q == IDLE)
                  | (state_q == FAULT);

  cdc_sync_2ff u_sync_e (
    .clk_i (ref_clk_i),
    .clr_i (sync_clr),
    .d_i   (pll_locked_e_core_i),
    .q_o   (lock_s[0])
  );

  cdc_sync_2ff u_sync_p (
    .clk_i (ref_clk_i),
    .clr_i (sync_clr),
    .d_i   (pll_locked_p_core_i),
    .q_o   (lock_s[1])
  );

  cdc_sync_2ff u_sync_sl (
    .clk_i (ref_clk_i),
    .clr_i (sync_clr),
    .d_i   (pll_locked_sl_i),
    .q_o   (lock_s[2])
  );

  assign all_lock = &lock_s;
  assign cfg_fire = cfg.cfg_valid_i & ready_q;

  always_comb begin
    tmo_d = (tmo_q == TMO_MAX) ? tmo_q
                               : tmo_q + TW'(1);
    stb_d = '0;
    if (all_lock) begin
      stb_d = (stb_q == STB_MAX) ? stb_q
                                 : stb_q + SW'(1);
    end
    gap_end = (gap_q == GAP_LAST);
    gap_d   = gap_end ? '0 : gap_q + GW'(1);
    step_nx = domain_e'(step_q + 3'd1);
    lost    = !all_lock
            && ((state_q == RELEASE)
             || (state_q == RUN));
    tmo_hit = (state_q == PLL_WAIT)
            && (stb_q != STB_MAX)
            && (tmo_d == TMO_MAX);
  end

  always_ff @(posedge ref_clk_i) begin
    if (srst_i) begin
      for (int i = 0; i < 3; i++) begin
        ref_q[i] <= DEF_REF_DIV;
        fb_q[i]  <= DEF_FB_DIV;
      end
    end else if (cfg_fire) begin
      for (int i = 0; i < 3; i++) begin
        if (cfg.cfg_sel_i == 2'(i)) begin
          ref_q[i] <= fix_ref(cfg.cfg_ref_div_i);
          fb_q[i]  <= fix_fb(cfg.cfg_fb_div_i);
        end
      end
    end
  end

  always_ff @(posedge ref_clk_i) begin
    if (srst_i) begin
      state_q  <= IDLE;
      step_q   <= SL;
      phase_q  <= 1'b0;
      tmo_q    <= '0;
      stb_q    <= '0;
      gap_q    <= '0;
      clk_en_q <= '0;
      arst_n_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ready_q  <= 1'b1;
      err_q    <= 1'b0;
      code_q   <= NONE;
      epll_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE, FAULT: begin
          if (start_i) begin
            state_q <= PLL_WAIT;
            tmo_q   <= '0;
            stb_q   <= '0;
            busy_q  <= 1'b1;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= NONE;
            epll_q  <= '0;
          end
        end
        PLL_WAIT: begin
          tmo_q <= tmo_d;
          stb_q <= stb_d;
          if (stb_q == STB_MAX) begin
            state_q      <= RELEASE;
            step_q       <= SL;
            phase_q      <= 1'b0;
            gap_q        <= '0;
            clk_en_q[SL] <= 1'b1;
          end
        end
        RELEASE: begin
          gap_q <= gap_d;
          // Each step: clock on, gap, reset off, gap.
          if (gap_end) begin
            if (!phase_q) begin
              arst_n_q[step_q] <= 1'b1;
              phase_q          <= 1'b1;
            end else if (step_q == E_CORE) begin
              state_q <= RUN;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              step_q            <= step_nx;
              clk_en_q[step_nx] <= 1'b1;
              phase_q           <= 1'b0;
            end
          end
        end
        RUN: begin
          done_q <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase

      if (lost || tmo_hit) begin
        state_q  <= FAULT;
        clk_en_q <= '0;
        arst_n_q <= '0;
        busy_q   <= 1'b0;
        done_q   <= 1'b0;
        ready_q  <= 1'b1;
        err_q    <= 1'b1;
        code_q   <= lost ? LOCK_LOSS : TIMEOUT;
        epll_q   <= ~lock_s;
      end
    end
  end

  assign cfg.cfg_ready_o = ready_q;

  assign pll_ref_div_e_core_o = ref_q[0];
  assign pll_ref_div_p_core_o = ref_q[1];
  assign pll_ref_div_sl_o     = ref_q[2];
  assign pll_fb_div_e_core_o  = fb_q[0];
  assign pll_fb_div_p_core_o  = fb_q[1];
  assign pll_fb_div_sl_o      = fb_q[2];

  assign clk_en_sl_o     = clk_en_q[SL];
  assign clk_en_pl_o     = clk_en_q[PL];
  assign clk_en_cl_o     = clk_en_q[CL];
  assign clk_en_p_core_o = clk_en_q[P_CORE];
  assign clk_en_e_core_o = clk_en_q[E_CORE];

  assign arst_sl_no     = arst_n_q[SL];
  assign arst_pl_no     = arst_n_q[PL];
  assign arst_cl_no     = arst_n_q[CL];
  assign arst_p_core_no = arst_n_q[P_CORE];
  assign arst_e_core_no = arst_n_q[E_CORE];

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign err_o      = err_q;
  assign err_code_o = code_q;
  assign err_pll_o  = epll_q;

endmodule

// File: tb/tb_clk_rst_seq.sv
// Scenario bench for clk_rst_seq: config writes, ordered
// release, timeout, lock loss, glitch filtering, resets.
module tb_clk_rst_seq;
  import clk_rst_seq_pkg::*;

  localparam int T = 4096;
  localparam int S = 8;
  localparam int G = 16;

  typedef struct packed {
    int         c;
    logic [4:0] en;
    logic [4:0] rn;
  } ev_t;

  logic        clk = 1'b0;
  logic        srst, start;
  logic        lk_e, lk_p, lk_sl;
  logic [3:0]  rd_e, rd_p, rd_sl;
  logic [11:0] fd_e, fd_p, fd_sl;
  logic        en_e, en_p, en_cl, en_sl, en_pl;
  logic        rn_e, rn_p, rn_cl, rn_sl, rn_pl;
  logic        busy, done, err;
  logic [1:0]  code;
  logic [2:0]  epll;
  logic [4:0]  en_v, rn_v;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [47:0] div_q[$];
  ev_t         ev_q[$];

  clk_rst_seq_if cfg_if ();

  clk_rst_seq dut (
    .ref_clk_i            (clk),
    .srst_i               (srst),
    .start_i              (start),
    .cfg                  (cfg_if),
    .pll_ref_div_e_core_o (rd_e),
    .pll_ref_div_p_core_o (rd_p),
    .pll_ref_div_sl_o     (rd_sl),
    .pll_fb_div_e_core_o  (fd_e),
    .pll_fb_div_p_core_o  (fd_p),
    .pll_fb_div_sl_o      (fd_sl),
    .pll_locked_e_core_i  (lk_e),
    .pll_locked_p_core_i  (lk_p),
    .pll_locked_sl_i      (lk_sl),
    .clk_en_e_core_o      (en_e),
    .clk_en_p_core_o      (en_p),
    .clk_en_cl_o          (en_cl),
    .clk_en_sl_o          (en_sl),
    .clk_en_pl_o          (en_pl),
    .arst_e_core_no       (rn_e),
    .arst_p_core_no       (rn_p),
    .arst_cl_no           (rn_cl),
    .arst_sl_no           (rn_sl),
    .arst_pl_no           (rn_pl),
    .busy_o               (busy),
    .done_o               (done),
    .err_o                (err),
    .err_code_o           (code),
    .err_pll_o            (epll)
  );

  assign en_v = {en_e, en_p, en_cl, en_pl, en_sl};
  assign rn_v = {rn_e, rn_p, rn_cl, rn_pl, rn_sl};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_srst();
    srst = 1'b1;
    tick();
    srst = 1'b0;
  endtask

  task automatic set_locks(input logic v);
    lk_e  = v;
    lk_p  = v;
    lk_sl = v;
  endtask

  task automatic test_reset();
    srst  = 1'b1;
    start = 1'b1;
    cfg_if.cfg_valid_i   = 1'b1;
    cfg_if.cfg_sel_i     = 2'd0;
    cfg_if.cfg_ref_div_i = 4'd9;
    cfg_if.cfg_fb_div_i  = 12'd9;
    set_locks(1'b1);
    tick();
    tick();
    srst  = 1'b0;
    start = 1'b0;
    cfg_if.cfg_valid_i = 1'b0;
    checks++;
    if ({rd_e, rd_p, rd_sl} !== {3{4'd1}}) begin
      errors++;
      $display("FAIL reset_ref got=%h want=111",
               {rd_e, rd_p, rd_sl});
    end
    checks++;
    if ({fd_e, fd_p, fd_sl} !== {3{12'd40}}) begin
      errors++;
      $display("FAIL reset_fb got=%h want=%h",
               {fd_e, fd_p, fd_sl}, {3{12'd40}});
    end
    checks++;
    if (en_v !== 5'd0 || rn_v !== 5'd0) begin
      errors++;
      $display("FAIL reset_en_rn got=%b/%b want=0/0",
               en_v, rn_v);
    end
    checks++;
    if ({busy, done, err, code, epll} !== 8'd0
        || cfg_if.cfg_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_status got=%b rdy=%b want=0 rdy=1",
               {busy, done, err, code, epll},
               cfg_if.cfg_ready_o);
    end
  endtask

  task automatic test_cfg_write();
    logic [3:0]  mref[3];
    logic [11:0] mfb[3];
    logic [47:0] got, exp;
    logic        tv[6] = '{1, 1, 1, 1, 0, 1};
    logic [1:0]  ts[6] = '{1, 0, 2, 3, 0, 1};
    logic [3:0]  tr[6] = '{0, 3, 15, 5, 7, 2};
    logic [11:0] tf[6] = '{80, 0, 4095, 5, 9, 80};
    for (int i = 0; i < 3; i++) begin
      mref[i] = 4'd1;
      mfb[i]  = 12'd40;
    end
    for (int i = 0; i < 6; i++) begin
      cfg_if.cfg_valid_i   = tv[i];
      cfg_if.cfg_sel_i     = ts[i];
      cfg_if.cfg_ref_div_i = tr[i];
      cfg_if.cfg_fb_div_i  = tf[i];
      if (tv[i] && ts[i] != 2'd3) begin
        mref[ts[i]] = (tr[i] == 0) ? 4'd1 : tr[i];
        mfb[ts[i]]  = (tf[i] == 0) ? 12'd1 : tf[i];
      end
      div_q.push_back({mref[0], mref[1], mref[2],
                       mfb[0], mfb[1], mfb[2]});
      tick();
      cfg_if.cfg_valid_i = 1'b0;
      got = {rd_e, rd_p, rd_sl, fd_e, fd_p, fd_sl};
      exp = div_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL cfg_write[%0d] got=%h want=%h",
                 i, got, exp);
      end
    end
    checks++;
    if (en_v !== 5'd0 || rn_v !== 5'd0
        || cfg_if.cfg_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL cfg_idle_out got=%b/%b rdy=%b",
               en_v, rn_v, cfg_if.cfg_ready_o);
    end
  endtask

  task automatic test_nominal();
    int         n, r, done_at;
    logic [4:0] pen, prn;
    ev_t        e;
    set_locks(1'b1);
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    n = cyc;
    checks++;
    if (busy !== 1'b1 || cfg_if.cfg_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL nom_busy got=%b rdy=%b want=1 rdy=0",
               busy, cfg_if.cfg_ready_o);
    end
    r = n + 3 + S;
    for (int i = 0; i < 5; i++) begin
      ev_q.push_back('{r + 2 * G * i,
                       5'((1 << (i + 1)) - 1),
                       5'((1 << i) - 1)});
      ev_q.push_back('{r + 2 * G * i + G,
                       5'((1 << (i + 1)) - 1),
                       5'((1 << (i + 1)) - 1)});
    end
    pen = en_v;
    prn = rn_v;
    done_at = -1;
    for (int k = 0; k < 400 && done_at < 0; k++) begin
      tick();
      if (en_v !== pen || rn_v !== prn) begin
        checks++;
        if (ev_q.size() == 0) begin
          errors++;
          $display("FAIL nom_extra cyc=%0d en=%b rn=%b",
                   cyc, en_v, rn_v);
        end else begin
          e = ev_q.pop_front();
          if (cyc != e.c || en_v !== e.en
              || rn_v !== e.rn) begin
            errors++;
            $display("FAIL nom_step got=%0d %b %b want=%0d %b %b",
                     cyc, en_v, rn_v, e.c, e.en, e.rn);
          end
        end
        pen = en_v;
        prn = rn_v;
      end
      if (done === 1'b1) done_at = cyc;
    end
    checks++;
    if (ev_q.size() != 0) begin
      errors++;
      $display("FAIL nom_missing got=%0d left want=0",
               ev_q.size());
      ev_q.delete();
    end
    checks++;
    if (done_at != r + 10 * G) begin
      errors++;
      $display("FAIL nom_done got=%0d want=%0d",
               done_at, r + 10 * G);
    end
    checks++;
    if (busy !== 1'b0 || err !== 1'b0
        || cfg_if.cfg_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL nom_run got busy=%b err=%b rdy=%b",
               busy, err, cfg_if.cfg_ready_o);
    end
  endtask

  task automatic test_lock_loss();
    int n;
    lk_sl = 1'b0;
    tick();
    tick();
    checks++;
    if (done !== 1'b1 || en_v !== 5'h1f) begin
      errors++;
      $display("FAIL loss_early got done=%b en=%b want 1 11111",
               done, en_v);
    end
    tick();
    checks++;
    if (en_v !== 5'd0 || rn_v !== 5'd0) begin
      errors++;
      $display("FAIL loss_outs got=%b/%b want=0/0",
               en_v, rn_v);
    end
    checks++;
    if ({err, code, epll} !== {1'b1, 2'd2, 3'b100}
        || done !== 1'b0
        || cfg_if.cfg_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL loss_err got=%b %0d %b done=%b rdy=%b",
               err, code, epll, done, cfg_if.cfg_ready_o);
    end
    lk_sl = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = cyc;
    checks++;
    if ({err, code, epll} !== 6'd0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL restart_clr got=%b %0d %b busy=%b",
               err, code, epll, busy);
    end
    for (int k = 0; k < 400; k++) begin
      tick();
      if (done === 1'b1) break;
    end
    checks++;
    if (done !== 1'b1 || cyc != n + 3 + S + 10 * G) begin
      errors++;
      $display("FAIL restart_done got=%b@%0d want=1@%0d",
               done, cyc, n + 3 + S + 10 * G);
    end
  endtask

  task automatic test_timeout();
    int n;
    lk_e  = 1'b0;
    lk_p  = 1'b1;
    lk_sl = 1'b1;
    do_srst();
    start = 1'b1;
    tick();
    start = 1'b0;
    n = cyc;
    for (int k = 0; k < T + 100; k++) begin
      tick();
      if (err === 1'b1) break;
    end
    checks++;
    if (err !== 1'b1 || cyc - n != T) begin
      errors++;
      $display("FAIL tmo_cycle got=%b@%0d want=1@%0d",
               err, cyc - n, T);
    end
    checks++;
    if (code !== 2'd1 || epll !== 3'b001
        || busy !== 1'b0 || en_v !== 5'd0) begin
      errors++;
      $display("FAIL tmo_err got=%0d %b busy=%b en=%b",
               code, epll, busy, en_v);
    end
    checks++;
    if (cfg_if.cfg_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL tmo_ready got=%b want=1",
               cfg_if.cfg_ready_o);
    end
    cfg_if.cfg_valid_i   = 1'b1;
    cfg_if.cfg_sel_i     = 2'd0;
    cfg_if.cfg_ref_div_i = 4'd5;
    cfg_if.cfg_fb_div_i  = 12'd100;
    tick();
    cfg_if.cfg_valid_i = 1'b0;
    checks++;
    if (rd_e !== 4'd5 || fd_e !== 12'd100) begin
      errors++;
      $display("FAIL tmo_cfg got=%0d/%0d want=5/100",
               rd_e, fd_e);
    end
  endtask

  task automatic test_glitch();
    int b2;
    set_locks(1'b0);
    do_srst();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    set_locks(1'b1);
    repeat (5) tick();
    set_locks(1'b0);
    tick();
    set_locks(1'b1);
    b2 = cyc + 1;
    checks++;
    if (en_v !== 5'd0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL glitch_hold got en=%b busy=%b",
               en_v, busy);
    end
    for (int k = 0; k < 100; k++) begin
      tick();
      if (en_sl === 1'b1) break;
    end
    checks++;
    if (en_sl !== 1'b1 || cyc != b2 + 2 + S) begin
      errors++;
      $display("FAIL glitch_rel got=%b@%0d want=1@%0d",
               en_sl, cyc, b2 + 2 + S);
    end
  endtask

  task automatic test_back_to_back();
    do_srst();
    set_locks(1'b1);
    cfg_if.cfg_valid_i   = 1'b1;
    cfg_if.cfg_sel_i     = 2'd1;
    cfg_if.cfg_ref_div_i = 4'd0;
    cfg_if.cfg_fb_div_i  = 12'd80;
    start = 1'b1;
    tick();
    cfg_if.cfg_valid_i = 1'b0;
    start = 1'b0;
    checks++;
    if (rd_p !== 4'd1 || fd_p !== 12'd80
        || busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b got=%0d/%0d busy=%b want=1/80 1",
               rd_p, fd_p, busy);
    end
    for (int k = 0; k < 300; k++) begin
      tick();
      if (en_cl === 1'b1) break;
    end
    checks++;
    if (en_v !== 5'b00111 || rn_v !== 5'b00011) begin
      errors++;
      $display("FAIL cl_step got=%b/%b want=00111/00011",
               en_v, rn_v);
    end
    repeat (4) tick();
    do_srst();
    checks++;
    if (en_v !== 5'd0 || rn_v !== 5'd0
        || {busy, done, err, code, epll} !== 8'd0
        || cfg_if.cfg_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL mid_rst got=%b/%b st=%b rdy=%b",
               en_v, rn_v, {busy, done, err, code, epll},
               cfg_if.cfg_ready_o);
    end
    checks++;
    if ({rd_e, rd_p, rd_sl} !== {3{4'd1}}
        || {fd_e, fd_p, fd_sl} !== {3{12'd40}}) begin
      errors++;
      $display("FAIL mid_rst_div got=%h %h",
               {rd_e, rd_p, rd_sl}, {fd_e, fd_p, fd_sl});
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $display("Result: errors=%0d of %0d checks",
             errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    srst  = 1'b1;
    start = 1'b0;
    set_locks(1'b0);
    cfg_if.cfg_valid_i   = 1'b0;
    cfg_if.cfg_sel_i     = 2'd0;
    cfg_if.cfg_ref_div_i = 4'd0;
    cfg_if.cfg_fb_div_i  = 12'd0;
    test_reset();
    test_cfg_write();
    test_nominal();
    test_lock_loss();
    test_timeout();
    test_glitch();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule

// File: doc/clk_rst_seq.md
# clk_rst_seq

Bring-up sequencer that sits directly upstream of `clk_rst_gen`. It holds the three PLL divider configurations and drives them, waits for all PLLs to lock, then enables clocks and releases the five domain resets in a fixed order. It also supervises lock, collapsing every domain back into reset on a lock timeout or a lock loss. It runs entirely on the reference clock.

## Interface
Parameters:
- `LOCK_TIMEOUT_CYCLES`, default 4096: maximum number of `ref_clk_i` cycles spent in PLL_WAIT.
- `LOCK_STABLE_CYCLES`, default 8: number of consecutive cycles all synchronised locks must be high.
- `RST_GAP_CYCLES`, default 16: gap between clock-enable and reset-release, and between steps.
- `DEF_REF_DIV`, default 4'd1: reset value of every ref divider.
- `DEF_FB_DIV`, default 12'd40: reset value of every fb divider.

Ports:
- `ref_clk_i`  in  1  single clock.
- `srst_i`  in  1  synchronous, active-high reset.
- `start_i`  in  1  begins a sequence; sampled only in IDLE or FAULT.
- `cfg_valid_i` / `cfg_ready_o`  in/out  1/1  divider-write handshake.
- `cfg_sel_i`  in  2  divider target: 0 = E core, 1 = P core, 2 = system link, 3 = none.
- `cfg_ref_div_i` / `cfg_fb_div_i`  in  4/12  divider values to write.
- `pll_ref_div_{e_core,p_core,sl}_o`  out  4  ref divider driven to the PLL.
- `pll_fb_div_{e_core,p_core,sl}_o`  out  12  fb divider driven to the PLL.
- `pll_locked_{e_core,p_core,sl}_i`  in  1  raw (asynchronous) PLL lock indications.
- `clk_en_{e_core,p_core,cl,sl,pl}_o`  out  1  per-domain clock enables.
- `arst_{e_core,p_core,cl,sl,pl}_no`  out  1  per-domain resets, active-low.
- `busy_o`, `done_o`  out  1/1  sequence status.
- `err_o`  out  1  sticky fault flag.
- `err_code_o`  out  2  0 = none, 1 = lock timeout, 2 = lock loss.
- `err_pll_o`  out  3  `{sl,p,e}` synchronised lock-low snapshot taken at fault entry.

## Operation
- FSM states: IDLE, PLL_WAIT, RELEASE, RUN, FAULT.
- Lock inputs each pass through a 2-FF synchroniser. All FSM decisions use the synchronised values.
- **Config writes.**
  - `cfg_ready_o` is 1 only in IDLE and FAULT.
  - On `cfg_valid_i & cfg_ready_o`, the selected divider pair updates on the next edge. `cfg_sel_i` = 3 completes the handshake but has no effect.
  - Zero values are stored as 1 (ref and fb independently).
- **IDLE.** All clock enables are 0 and all resets asserted.
  - `start_i` moves the FSM to PLL_WAIT and clears `err_o`, `err_code_o` and `err_pll_o`.
  - A config write and `start_i` in the same cycle: both take effect, and the new divider is presented in PLL_WAIT.
- **PLL_WAIT.**
  - The timeout counter increments every cycle.
  - The stable counter increments while all three synchronised locks are 1, and clears to 0 when any lock is 0.
  - When the stable counter reaches `LOCK_STABLE_CYCLES`, go to RELEASE.
  - Otherwise, when the timeout counter reaches `LOCK_TIMEOUT_CYCLES`, go to FAULT with code 1. If both conditions occur in the same cycle, RELEASE wins.
- **RELEASE.** Steps run in the order SL, PL, CL, P_CORE, E_CORE.
  - Each step sets its `clk_en` on entry.
  - After `RST_GAP_CYCLES` the step deasserts its reset (`arst_*_no` = 1).
  - After a further `RST_GAP_CYCLES` the next step begins.
  - After the E_CORE reset has been released and its gap has elapsed, go to RUN.
- **RUN.** `done_o` = 1.
- **Lock loss.** Any synchronised lock falling to 0 in RELEASE or RUN causes FAULT with code 2.
- **FAULT.**
  - In the same cycle as entry: every `clk_en` = 0, every reset asserted, `err_pll_o` captured, `err_o` = 1.
  - `start_i` restarts the sequence at PLL_WAIT.
- `busy_o` = 1 in PLL_WAIT and RELEASE.
- `srst_i` overrides everything in any state. It returns the FSM to IDLE with all reset values, including the divider defaults.

## Timing
- **Reset values:**
  - dividers: `DEF_REF_DIV` / `DEF_FB_DIV`
  - all `clk_en` = 0, all `arst_*_no` = 0
  - `busy_o`, `done_o`, `err_o`, `err_code_o`, `err_pll_o` = 0
  - `cfg_ready_o` = 1
- All outputs are registered; there are no combinational input-to-output paths.
- Divider outputs change on the edge that completes the handshake.
- Lock path latency:
  - raw lock to synchronised lock: 2 cycles.
  - lock loss (raw falling) to FAULT outputs: 3 cycles.
- With locks stable before `start_i`: `start_i` sampled at edge N means PLL_WAIT at N+1. RELEASE is entered at N+3+`LOCK_STABLE_CYCLES`. `done_o` rises `10*RST_GAP_CYCLES` cycles after RELEASE entry.
- Counters are sized `$clog2(param+1)` and saturate; they never wrap.

## Structure
- Package `clk_rst_seq_pkg` holds:
  - `seq_state_e`
  - `err_code_e` (NONE, TIMEOUT, LOCK_LOSS)
  - `domain_e` (SL, PL, CL, P_CORE, E_CORE), which also defines the release order
  - the divider width constants (4, 12)
- Sub-module `cdc_sync_2ff`, instantiated three times, one per lock input.

## Test plan
- **Reset and write:** `srst_i`, then write sel=1, ref=0, fb=80 → `pll_ref_div_p_core_o` = 1, `pll_fb_div_p_core_o` = 80. All resets stay low and all enables stay 0.
- **Nominal sequence:** locks high, `start_i` → enables and resets follow the SL, PL, CL, P, E order at 16-cycle spacing. `done_o` rises exactly 160 cycles after RELEASE entry.
- **Timeout:** E lock held low → FAULT after 4096 PLL_WAIT cycles with `err_code_o` = 1 and `err_pll_o` = 3'b001. `cfg_ready_o` = 1 in FAULT.
- **Lock loss in RUN:** drop SL lock → 3 cycles later all enables are 0, all resets asserted, `err_code_o` = 2 and `err_pll_o` = 3'b100. `start_i` then resequences.
- **Glitch filter:** in PLL_WAIT, a 5-cycle lock-high burst followed by 1 cycle low → no RELEASE. A following 8-cycle stable window → RELEASE.
- **Mid-sequence reset:** `srst_i` during the CL step → next cycle the FSM is in IDLE, all outputs are at reset values and the dividers are back to their defaults.
